mmio_timer: RTL
===============

MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 Parameter BASE_ADDR, default 9'h180, word address of the first of four timer registers.
REQ-002 Parameter PRESCALE, default 16'd50000, clock cycles per count tick; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mem_cmd  input  2  bus command: 2'b01 read, 2'b10 write; 2'b00 and 2'b11 are no-op.
REQ-006 mem_addr  input  9  bus word address.
REQ-007 write_data  input  16  bus write data.
REQ-008 read_data  output  16  register read value; 16'h0000 when rd_hit=0.
REQ-009 rd_hit  output  1  high when mem_cmd=read and mem_addr is inside the window; drives the top-level tri-state enable.
REQ-010 irq  output  1  done AND irq_en.

Function
REQ-011 Register map: BASE+0 LOAD (R/W, 16b); BASE+1 CTRL (R/W, bit0 en, bit1 irq_en, bits15:2 read 0); BASE+2 COUNT (read-only); BASE+3 STATUS (bit0 done, bits15:1 read 0).
REQ-012 Reads are combinational, same cycle; writes take effect at the next rising clk edge.
REQ-013 Writes to COUNT and to addresses outside BASE..BASE+3 are ignored; no register changes.
REQ-014 Prescaler counts 0..PRESCALE-1 only in RUN and emits a one-cycle tick when it wraps to 0; with PRESCALE=1, tick is high every RUN cycle.
REQ-015 FSM states IDLE, RUN, EXPIRED; state encoding is internal and not visible on the bus.
REQ-016 IDLE: CTRL write with en=1 -> COUNT<=LOAD, prescaler<=0, go RUN.
REQ-017 RUN, tick and COUNT!=0 -> COUNT<=COUNT-1.
REQ-018 RUN, tick and COUNT==0 -> done<=1; go EXPIRED, en<=0 (reload behaviour per REQ-028).
REQ-019 EXPIRED: COUNT holds 0; CTRL write with en=1 -> reload per REQ-016, go RUN.
REQ-020 CTRL write with en=0 in any state -> IDLE next edge; COUNT holds value; done unchanged.
REQ-021 CTRL write with en=1 while in RUN -> no reload, no state change; irq_en updates.
REQ-022 LOAD written while RUN: takes effect only on next reload; current count unaffected.
REQ-023 LOAD=0 with en=1: done sets on first tick after start.
REQ-024 STATUS write with bit0=1 clears done; bit0=0 writes have no effect.
REQ-025 Done set and STATUS clear in the same cycle: set wins, done stays 1.

Reset
REQ-026 On reset assertion, immediately and without clk: LOAD=0, CTRL=0, COUNT=0, done=0, prescaler=0, state=IDLE; irq=0.
REQ-027 Reset mid-count aborts the count; on reset release the block stays in IDLE until a CTRL write sets en=1.

Configuration
REQ-028 Macro TIMER_AUTORELOAD_EN: when defined, CTRL bit2 is R/W "auto"; RUN with tick, COUNT==0 and auto=1 sets done, reloads COUNT<=LOAD and stays RUN with en=1; when auto=0, REQ-018 applies. When the macro is undefined, bit2 reads 0, writes to it are ignored, and REQ-018 always applies.

Verification (PRESCALE=1, BASE_ADDR=9'h180)
REQ-029 Reset asserted -> read_data=0 at 9'h180..9'h183; irq=0; rd_hit=1 only for mem_cmd=01 inside the window.
REQ-030 Write LOAD=3, then write CTRL=16'h0003 -> COUNT reads 3,2,1,0 on the next four edges; done=1 and irq=1 after the 5th edge; CTRL reads 16'h0002.
REQ-031 In EXPIRED, write STATUS=1 -> done=0 and irq=0 next edge; the same write on the edge where done sets -> done stays 1.
REQ-032 LOAD=5, running at COUNT=2, write CTRL=0 -> COUNT holds 2 in IDLE; write CTRL=1 -> COUNT=5.
REQ-033 With TIMER_AUTORELOAD_EN, LOAD=2, CTRL=16'h0005 -> COUNT sequence 2,1,0,2,1,0; done set at each wrap; en stays 1.
REQ-034 Assert reset while COUNT=7 in RUN -> all outputs 0 before the next clk edge; write to 9'h182 ignored; read of 9'h17F gives rd_hit=0, read_data=0.

Source files
------------

// File: rtl/mmio_timer.sv
// -----------------------------------------------------------------------------
// mmio_timer
//   Memory-mapped down-counting timer with a prescaler and an interrupt.
//   Four word registers start at BASE_ADDR:
//     +0 LOAD   (R/W) value copied into COUNT when the timer starts
//     +1 CTRL   (R/W) bit0 en, bit1 irq_en, bit2 auto (only with the macro)
//     +2 COUNT  (RO)  current count
//     +3 STATUS (R/W1C) bit0 done
//   Reads are combinational. Writes land on the next rising clk edge.
//
//   Optional feature macro: TIMER_AUTORELOAD_EN
//     When defined, CTRL bit2 "auto" makes the timer reload COUNT from LOAD
//     on expiry and keep running. When undefined, bit2 reads 0 and is
//     ignored on write.
//
// Ports
//   clk         single clock, rising-edge
//   reset       asynchronous active-high reset
//   mem_cmd     2'b01 read, 2'b10 write, others no-op
//   mem_addr    9-bit word address
//   write_data  16-bit write data
//   read_data   16-bit read data, zero when rd_hit is low
//   rd_hit      read strobe inside the register window (tri-state enable)
//   irq         done AND irq_en
// -----------------------------------------------------------------------------
module mmio_timer #(
    parameter logic [8:0]  BASE_ADDR = 9'h180,
    parameter logic [15:0] PRESCALE  = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        rd_hit,
    output logic        irq
);

    localparam logic [1:0]  CMD_RD    = 2'b01;
    localparam logic [1:0]  CMD_WR    = 2'b10;
    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 16'd1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [15:0] load_q, load_n;
    logic [15:0] count_q, count_n;
    logic [15:0] presc_q, presc_n;
    logic        en_q, en_n;
    logic        irq_en_q, irq_en_n;
    logic        done_q, done_n;
    logic        auto_q;
`ifdef TIMER_AUTORELOAD_EN
    logic        auto_n;
`endif

    // Address decode. The offset is taken modulo the 9-bit address space, so
    // addresses below BASE_ADDR wrap to large offsets and fall outside.
    logic [8:0] offset;
    logic       in_win;
    logic       wr_load, wr_ctrl, wr_status;
    logic       tick;

    assign offset    = mem_addr - BASE_ADDR;
    assign in_win    = (offset < 9'd4);
    assign rd_hit    = (mem_cmd == CMD_RD) && in_win;
    assign wr_load   = (mem_cmd == CMD_WR) && in_win && (offset[1:0] == 2'd0);
    assign wr_ctrl   = (mem_cmd == CMD_WR) && in_win && (offset[1:0] == 2'd1);
    assign wr_status = (mem_cmd == CMD_WR) && in_win && (offset[1:0] == 2'd3);

    // The prescaler only advances in RUN; its last value marks the tick.
    assign tick = (state == RUN) && (presc_q == PRESC_MAX);
    assign irq  = done_q & irq_en_q;

`ifndef TIMER_AUTORELOAD_EN
    assign auto_q = 1'b0;
`endif

    // State register and all timer state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            load_q   <= '0;
            count_q  <= '0;
            presc_q  <= '0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
            auto_q   <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            load_q   <= load_n;
            count_q  <= count_n;
            presc_q  <= presc_n;
            en_q     <= en_n;
            irq_en_q <= irq_en_n;
            done_q   <= done_n;
`ifdef TIMER_AUTORELOAD_EN
            auto_q   <= auto_n;
`endif
        end
    end

    // Next-state and register update logic
    always_comb begin
        state_n  = state;
        load_n   = load_q;
        count_n  = count_q;
        presc_n  = presc_q;
        en_n     = en_q;
        irq_en_n = irq_en_q;
        done_n   = done_q;
`ifdef TIMER_AUTORELOAD_EN
        auto_n   = auto_q;
`endif

        if (wr_load) begin
            load_n = write_data;
        end
        // Clear comes first so that an expiry in the same cycle overrides it.
        if (wr_status && write_data[0]) begin
            done_n = 1'b0;
        end
        if (wr_ctrl) begin
            irq_en_n = write_data[1];
`ifdef TIMER_AUTORELOAD_EN
            auto_n   = write_data[2];
`endif
        end

        case (state)
            IDLE, EXPIRED: begin
                if (wr_ctrl) begin
                    en_n = write_data[0];
                    if (write_data[0]) begin
                        count_n = load_q;
                        presc_n = '0;
                        state_n = RUN;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            RUN: begin
                if (wr_ctrl && !write_data[0]) begin
                    // Stop: count and done are frozen where they are.
                    en_n    = 1'b0;
                    state_n = IDLE;
                end else if (tick) begin
                    presc_n = '0;
                    if (count_q != 16'd0) begin
                        count_n = count_q - 16'd1;
                    end else begin
                        done_n = 1'b1;
                        if (auto_q) begin
                            count_n = load_q;
                        end else begin
                            en_n    = 1'b0;
                            state_n = EXPIRED;
                        end
                    end
                end else begin
                    presc_n = presc_q + 16'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Combinational read mux
    always_comb begin
        read_data = 16'h0000;
        if (rd_hit) begin
            case (offset[1:0])
                2'd0:    read_data = load_q;
                2'd1:    read_data = {13'b0, auto_q, irq_en_q, en_q};
                2'd2:    read_data = count_q;
                default: read_data = {15'b0, done_q};
            endcase
        end
    end

endmodule
